// File: rtl/rgb_pkg.sv
// Shared colour-LUT definitions: code widths, colour codes and their RGB words.
// The block memory is initialised from colour_rgb(), and the bench model uses the same constants.
package rgb_pkg;

    localparam int COLOUR_W = 3;
    localparam int RGB_W    = 24;

    typedef enum logic [COLOUR_W-1:0] {
        BLACK   = 3'd0,
        BLUE    = 3'd1,
        GREEN   = 3'd2,
        CYAN    = 3'd3,
        RED     = 3'd4,
        MAGENTA = 3'd5,
        YELLOW  = 3'd6,
        WHITE   = 3'd7
    } colour_e;

    localparam logic [RGB_W-1:0] RGB_BLACK   = 24'h000000;
    localparam logic [RGB_W-1:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [RGB_W-1:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [RGB_W-1:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [RGB_W-1:0] RGB_RED     = 24'hFF0000;
    localparam logic [RGB_W-1:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [RGB_W-1:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [RGB_W-1:0] RGB_WHITE   = 24'hFFFFFF;

    function automatic logic [RGB_W-1:0] colour_rgb(colour_e c);
        case (c)
            BLACK:   return RGB_BLACK;
            BLUE:    return RGB_BLUE;
            GREEN:   return RGB_GREEN;
            CYAN:    return RGB_CYAN;
            RED:     return RGB_RED;
            MAGENTA: return RGB_MAGENTA;
            YELLOW:  return RGB_YELLOW;
            default: return RGB_WHITE;
        endcase
    endfunction

endpackage

// File: rtl/rgb_lut_arbiter_if.sv
// Request and response channels between the colour producers/consumer and the LUT arbiter.
interface rgb_lut_arbiter_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    import rgb_pkg::*;

    logic [NREQ-1:0]          req_valid;
    logic [COLOUR_W*NREQ-1:0] req_colour;
    logic [NREQ-1:0]          req_ready;
    logic                     rsp_valid;
    logic [IDW-1:0]           rsp_id;
    logic [RGB_W-1:0]         rsp_rgb;
    logic                     rsp_ready;

    modport slave (
        input  req_valid, req_colour, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rgb
    );

    modport master (
        output req_valid, req_colour, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rgb
    );

endinterface

// File: rtl/rgb_lut_arbiter_rr_arbiter.sv
// Round-robin pick: same-cycle one-hot grant scanning from ptr+1; the pointer follows each grant.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] valid,
    input  logic            allow,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            fire
);

    logic [IDW-1:0] ptr;

    always_comb begin
        int             idx;
        logic [IDW-1:0] sel;
        grant    = '0;
        grant_id = '0;
        fire     = 1'b0;
        idx      = 0;
        sel      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            sel = IDW'(idx);
            if (allow && !fire && valid[sel]) begin
                fire       = 1'b1;
                grant[sel] = 1'b1;
                grant_id   = sel;
            end
        end
    end

    // Pointer starts on the last requester so requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= IDW'(NREQ - 1);
        end else if (fire) begin
            ptr <= grant_id;
        end
    end

endmodule

// File: rtl/rgb_lut_arbiter.sv
// Shares the colour-LUT block memory between NREQ requesters; one read per grant,
// responses returned in grant order through a 2-entry buffer with credit-based issue.
module rgb_lut_arbiter
    import rgb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    rgb_lut_arbiter_if.slave    bus,
    output logic                mem_en,
    output logic                mem_we,
    output logic [COLOUR_W-1:0] mem_addr,
    input  logic [RGB_W-1:0]    mem_rdata
);

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [RGB_W-1:0] rgb;
    } entry_t;

    logic [1:0]          count;
    logic                inflight;
    logic [IDW-1:0]      tag;
    logic [COLOUR_W-1:0] addr_q;
    entry_t              e0;
    entry_t              e1;
    entry_t              cap_e;

    logic                pop;
    logic [1:0]          occ;
    logic                allow;
    logic                fire;
    logic [IDW-1:0]      grant_id;
    logic [COLOUR_W-1:0] granted_colour;

    assign pop   = (count != 2'd0) && bus.rsp_ready;
    assign occ   = count + {1'b0, inflight};
    // A read is only issued when its data is guaranteed a buffer slot next cycle.
    assign allow = rst && ((occ - {1'b0, pop}) < 2'd2);

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .valid    (bus.req_valid),
        .allow    (allow),
        .grant    (bus.req_ready),
        .grant_id (grant_id),
        .fire     (fire)
    );

    assign granted_colour = bus.req_colour[grant_id*COLOUR_W +: COLOUR_W];
    assign mem_en   = fire;
    assign mem_we   = 1'b0;
    assign mem_addr = fire ? granted_colour : addr_q;
    assign cap_e    = {tag, mem_rdata};

    always_ff @(posedge clk) begin
        if (!rst) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            tag      <= '0;
            addr_q   <= '0;
            e0       <= '0;
            e1       <= '0;
        end else begin
            inflight <= fire;
            if (fire) begin
                tag    <= grant_id;
                addr_q <= granted_colour;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
            // e0 is the head; a pop shifts e1 forward, a capture fills the first free slot.
            case ({inflight, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= cap_e;
                    else               e1 <= cap_e;
                end
                2'b01: e0 <= e1;
                2'b11: begin
                    if (count == 2'd1) begin
                        e0 <= cap_e;
                    end else begin
                        e0 <= e1;
                        e1 <= cap_e;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (count != 2'd0);
    assign bus.rsp_id    = e0.id;
    assign bus.rsp_rgb   = e0.rgb;

endmodule

// File: tb/tb_rgb_lut_arbiter.sv
// Randomised and directed bench for rgb_lut_arbiter against a cycle-stamped queue model.
module tb_rgb_lut_arbiter;
    import rgb_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_en;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [23:0] mem_rdata = 24'h0;

    always #5 clk = ~clk;

    rgb_lut_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    rgb_lut_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    // Block memory: registered read, one cycle after ena.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= colour_rgb(colour_e'(mem_addr));
    end

    typedef struct {
        int          id;
        logic [23:0] rgb;
        int          due;
    } rsp_t;

    typedef struct {
        int          id;
        logic [23:0] rgb;
    } obs_t;

    rsp_t        q[$];
    obs_t        obs[$];
    int          ptr = NREQ - 1;
    int          now = 0;
    int          rst_cycles = 0;
    int          grant_idx = -1;
    logic [2:0]  last_addr = 3'd0;
    int          dut_grants = 0;
    bit          seen_white = 1'b0;
    logic [NREQ-1:0] last_ready = '0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [23:0] ref_rgb(logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, now);
        end
    endtask

    // One clock: inputs already set after the previous falling edge; sample 1 ns later.
    task automatic cycle();
        bit              hv;
        bit              pop;
        logic [NREQ-1:0] exp_ready;
        logic [2:0]      col;
        #1;
        last_ready = bus.req_ready;
        if (!rst) begin
            check("rst_req_ready", 32'(bus.req_ready), 32'd0);
            check("rst_mem_en", 32'(mem_en), 32'd0);
            if (rst_cycles > 0) begin
                check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
                check("rst_rsp_rgb", 32'(bus.rsp_rgb), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'd0);
            end
            rst_cycles++;
            q.delete();
            ptr       = NREQ - 1;
            last_addr = 3'd0;
            grant_idx = -1;
        end else begin
            rst_cycles = 0;
            if (|(bus.req_valid & bus.req_ready)) dut_grants++;
            if (bus.rsp_valid && bus.rsp_rgb == 24'hFFFFFF) seen_white = 1'b1;
            if (bus.rsp_valid && bus.rsp_ready) obs.push_back('{int'(bus.rsp_id), bus.rsp_rgb});

            hv  = (q.size() > 0) && (q[0].due <= now);
            pop = hv && bus.rsp_ready;
            check("rsp_valid", 32'(bus.rsp_valid), 32'(hv));
            if (hv) begin
                check("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
                check("rsp_rgb", 32'(bus.rsp_rgb), 32'(q[0].rgb));
            end

            grant_idx = -1;
            if (q.size() - int'(pop) < 2) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (ptr + k) % NREQ;
                    if (grant_idx < 0 && bus.req_valid[i]) grant_idx = i;
                end
            end
            exp_ready = '0;
            if (grant_idx >= 0) exp_ready[grant_idx] = 1'b1;
            check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
            check("mem_en", 32'(mem_en), 32'(grant_idx >= 0));
            if (grant_idx >= 0) begin
                col       = bus.req_colour[3*grant_idx +: 3];
                last_addr = col;
            end
            check("mem_addr", 32'(mem_addr), 32'(last_addr));
            check("mem_we", 32'(mem_we), 32'd0);

            if (pop) void'(q.pop_front());
            if (grant_idx >= 0) begin
                q.push_back('{grant_idx, ref_rgb(last_addr), now + 2});
                ptr = grant_idx;
            end
        end
        now++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        int g0;
        bit granted;
        bus.req_valid  = '1;
        bus.req_colour = 6'o75;
        bus.rsp_ready  = 1'b1;

        // Reset held with requests pending.
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b1;
        idle(2);

        // Single request: red from requester 0.
        bus.req_valid  = 2'b01;
        bus.req_colour = {3'd0, 3'd4};
        cycle();
        check("single_grant", 32'(last_ready), 32'd1);
        idle(4);

        // Round robin: both valid, blue and yellow.
        bus.req_valid  = 2'b11;
        bus.req_colour = {3'd6, 3'd1};
        bus.rsp_ready  = 1'b1;
        for (int k = 0; k < 10; k++) cycle();
        idle(4);

        // Backpressure: only two reads may complete while blocked.
        g0 = dut_grants;
        bus.req_valid  = 2'b01;
        bus.req_colour = {3'd0, 3'd2};
        bus.rsp_ready  = 1'b0;
        for (int k = 0; k < 6; k++) cycle();
        check("bp_grants", 32'(dut_grants - g0), 32'd2);
        g0 = dut_grants;
        bus.rsp_ready = 1'b1;
        cycle();
        check("bp_pop_grant", 32'(dut_grants - g0), 32'd1);
        g0 = dut_grants;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        check("bp_hold_grants", 32'(dut_grants - g0), 32'd0);
        idle(5);

        // Reset the cycle after issuing white; the read must vanish.
        bus.req_valid  = 2'b01;
        bus.req_colour = {3'd0, 3'd7};
        cycle();
        bus.req_valid = 2'b00;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        seen_white     = 1'b0;
        bus.req_valid  = 2'b11;
        bus.req_colour = {3'd5, 3'd3};
        cycle();
        check("post_rst_grant", 32'(last_ready), 32'd1);
        for (int k = 0; k < 4; k++) cycle();
        idle(4);
        check("rst_no_white", 32'(seen_white), 32'd0);

        // Sweep all colours from requester 1 with random consumer stalls.
        obs.delete();
        for (int c = 0; c < 8; c++) begin
            granted        = 1'b0;
            bus.req_valid  = 2'b10;
            bus.req_colour = {3'(c), 3'd0};
            for (int t = 0; t < 30 && !granted; t++) begin
                bus.rsp_ready = 1'($urandom_range(0, 1));
                cycle();
                if (grant_idx == 1) granted = 1'b1;
            end
            check("sweep_grant", 32'(granted), 32'd1);
        end
        idle(6);
        check("sweep_count", 32'(obs.size()), 32'd8);
        for (int k = 0; k < 8 && k < obs.size(); k++) begin
            check("sweep_rgb", 32'(obs[k].rgb), 32'(ref_rgb(3'(k))));
            check("sweep_id", 32'(obs[k].id), 32'd1);
        end

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            bus.req_valid  = 2'($urandom_range(0, 3));
            bus.req_colour = 6'($urandom);
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
            cycle();
        end
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_lut_arbiter.md
Name: rgb_lut_arbiter

Overview:
Shares the single-port 8-entry colour-to-RGB block memory (3-bit address, 24-bit data, 1-cycle registered read) between NREQ requesters.
- Round-robin arbitration over valid/ready request channels.
- Issues one memory read per grant and tracks the 1-cycle read latency.
- Returns each RGB word, tagged with the requester ID, on one shared response channel with backpressure.
- Sits between the colour-producing blocks and the colour-LUT block memory instance; it is the only driver of that memory's port.

Parameters:
NREQ, 2, number of requesters (2..4)
IDW, 1, width of the requester ID (clog2(NREQ), minimum 1)

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  reset, synchronous, active-low
req_valid  in  NREQ  request i has a colour pending
req_colour  in  3*NREQ  colour code of requester i, packed in bits [3i+2:3i]
req_ready  out  NREQ  one-hot grant; a request transfers when req_valid[i] and req_ready[i] are both high
mem_en  out  1  memory enable (drives ena); high exactly in issue cycles
mem_we  out  1  tied 0 (read-only use)
mem_addr  out  3  memory address (drives addra) = granted colour
mem_rdata  in  24  memory read data (douta); valid the cycle after mem_en
rsp_valid  out  1  response available
rsp_id  out  IDW  requester index of the response
rsp_rgb  out  24  RGB word {R[7:0],G[7:0],B[7:0]}
rsp_ready  in  1  consumer accepts the response; pop when rsp_valid and rsp_ready

Behaviour:
- Reset (rst==0 at a clock edge), held for as long as rst is low:
  - req_ready=0, mem_en=0, mem_addr=0, rsp_valid=0, rsp_id=0, rsp_rgb=0.
  - Output buffer emptied, inflight flag cleared, RR pointer set to NREQ-1 (requester 0 has first priority).
- Reset mid-operation: an inflight read is discarded; mem_rdata in the cycle after reset is ignored.
- Output buffer: 2-entry FIFO of {id,rgb}.
  - Head drives rsp_id/rsp_rgb; rsp_valid = buffer not empty.
  - Registered outputs; the head is stable while rsp_valid && !rsp_ready.
- Credit rule: occ = buffer entries + inflight (0..2).
  - Issue is allowed in a cycle iff (occ - pop) < 2, where pop = rsp_valid && rsp_ready.
  - The buffer therefore never overflows; no read data is ever dropped.
- Arbitration (combinational, same cycle):
  - If issue is allowed, grant the first i with req_valid[i], scanning from ptr+1 modulo NREQ.
  - req_ready = onehot(i); otherwise req_ready = 0.
  - req_ready never asserts for a requester whose req_valid is low.
- Issue cycle (grant to i):
  - mem_en=1, mem_addr=req_colour[i].
  - inflight set with tag i; ptr <- i.
- Capture, the cycle after issue:
  - {tag, mem_rdata} written to the buffer tail; inflight cleared unless a new issue occurs in the same cycle.
  - Capture and issue in the same cycle is legal.
  - Capture and pop in the same cycle is legal: occupancy stays constant, order is preserved.
- Latency: request handshake in cycle T -> rsp_valid at T+2 when the buffer was empty.
- Throughput: one response per cycle while rsp_ready is high.
- Ordering: responses leave in grant order.
- Fairness: with all requesters valid, grants rotate 0,1,..,NREQ-1,0 with no requester granted twice within NREQ grants.
- Backpressure: with rsp_ready=0, at most 2 reads complete. After that req_ready stays 0 until a pop occurs.
  - In the pop cycle one grant may issue (occ-pop = 1).
- Simultaneous events: all arbitration is same-cycle; the only simultaneous case needing a rule is issue + capture + pop, which is legal with occupancy updated as +capture-pop.
- mem_en is never high when issue is not allowed; mem_addr holds its last value when idle.

Decomposition:
- Shared package rgb_pkg holds:
  - COLOUR_W=3 and RGB_W=24.
  - Colour code constants: BLACK=0, BLUE=1, GREEN=2, CYAN=3, RED=4, MAGENTA=5, YELLOW=6, WHITE=7.
  - Expected RGB constants, shared with the bench model.
- One sub-module, rr_arbiter (NREQ-wide round-robin pick from pointer; combinational grant plus the pointer register).
- The 2-entry FIFO stays inline.

Test Plan:
- Reset/idle: rst=0 for 3 cycles with all req_valid=1 -> req_ready=0, mem_en=0, rsp_valid=0, rsp_rgb=0 throughout.
- Single request: req0 colour 4 at cycle T -> mem_en=1 with mem_addr=4 at T; at T+2 rsp_valid=1, rsp_id=0, rsp_rgb=24'hFF0000.
- Round-robin: both requesters always valid (req0 colour 1, req1 colour 6), rsp_ready=1 -> grants 0,1,0,1 each cycle.
  - Responses 0000FF/id0, FFFF00/id1 alternating, one per cycle.
- Backpressure: rsp_ready=0 while req0 is valid with colour 2.
  - Exactly 2 grants occur, then req_ready=0; rsp_rgb stays 00FF00 stable.
  - Raising rsp_ready for one cycle -> exactly 1 new grant in that cycle; no response lost or duplicated.
- Reset mid-read: rst low in the cycle after the issue of colour 7 -> no FFFFFF response appears after rst releases.
  - The first post-reset grant goes to requester 0.
- Sweep: requester 1 issues colours 0..7 with random rsp_ready -> responses in order 000000, 0000FF, 00FF00, 00FFFF, FF0000, FF00FF, FFFF00, FFFFFF, all with id 1.
